// File: rtl/axi_rd_credit_limit_if.sv
// AXI read-channel bundle (AR + R) used on both sides of the credit limiter.
// The master modport drives AR and rready; the slave modport answers them.
interface axi_rd_credit_limit_if #(
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_credit_limit.sv
// Read-path credit limiter: admits an AR burst only if the read-data buffer
// has room for all of its beats and the outstanding-burst cap is not reached.
// AR goes through a one-entry register slice; R passes straight through and
// every R beat hands its credit back.
module axi_rd_credit_limit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int MAX_BEATS  = 32,
  parameter int MAX_BURSTS = 8,
  localparam int CW        = $clog2(MAX_BEATS + 256 + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  axi_rd_credit_limit_if.slave     s_axi,
  axi_rd_credit_limit_if.master    m_axi,
  output logic [CW-1:0]            outstanding_beats,
  output logic [8:0]               outstanding_bursts
);

  localparam logic [CW:0] MAX_BEATS_W  = (CW+1)'(MAX_BEATS);
  localparam logic [9:0]  MAX_BURSTS_W = 10'(MAX_BURSTS);

  // AR slice registers
  logic [ID_WIDTH-1:0]   arid_q,    arid_d;
  logic [ADDR_WIDTH-1:0] araddr_q,  araddr_d;
  logic [7:0]            arlen_q,   arlen_d;
  logic [2:0]            arsize_q,  arsize_d;
  logic [1:0]            arburst_q, arburst_d;
  logic                  arvalid_q, arvalid_d;

  // Credit counters
  logic [CW-1:0] beats_q,  beats_d;
  logic [8:0]    bursts_q, bursts_d;

  logic [CW:0]   beats_need;
  logic [CW:0]   beats_sum;
  logic [9:0]    bursts_sum;
  logic          fits;
  logic          burst_room;
  logic          idle;
  logic          ok;
  logic          s_arready;
  logic          accept;
  logic          r_beat;
  logic          r_last;
  logic [DATA_WIDTH-1:0] r_data;

  // R path: pure wires, zero latency
  assign r_data       = m_axi.rdata;
  assign s_axi.rdata  = r_data;
  assign s_axi.rid    = m_axi.rid;
  assign s_axi.rresp  = m_axi.rresp;
  assign s_axi.rlast  = m_axi.rlast;
  assign s_axi.rvalid = m_axi.rvalid;
  assign m_axi.rready = s_axi.rready;

  assign r_beat = m_axi.rvalid & s_axi.rready;
  assign r_last = r_beat & m_axi.rlast;

  // Credit check against registered counters only; beats released this
  // cycle are not credited until the next one. An empty limiter always
  // admits, which lets a burst larger than the buffer through on its own.
  always_comb begin
    beats_need = {1'b0, beats_q} + (CW+1)'(s_axi.arlen) + (CW+1)'(1);
    fits       = (beats_need <= MAX_BEATS_W);
    burst_room = ({1'b0, bursts_q} < MAX_BURSTS_W);
    idle       = (beats_q == '0) && (bursts_q == '0);
    ok         = (fits && burst_room) || idle;
    s_arready  = rst_n & ok & (~arvalid_q | m_axi.arready);
    accept     = s_axi.arvalid & s_arready;
  end

  assign s_axi.arready = s_arready;

  // AR slice next state: capture on accept, drop valid once taken downstream
  always_comb begin
    arid_d    = arid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    arvalid_d = arvalid_q;
    if (accept) begin
      arid_d    = s_axi.arid;
      araddr_d  = s_axi.araddr;
      arlen_d   = s_axi.arlen;
      arsize_d  = s_axi.arsize;
      arburst_d = s_axi.arburst;
      arvalid_d = 1'b1;
    end else if (m_axi.arready) begin
      arvalid_d = 1'b0;
    end
  end

  // Counter next state: reserve on accept, release per R beat, never below 0
  always_comb begin
    beats_sum  = {1'b0, beats_q};
    bursts_sum = {1'b0, bursts_q};
    if (accept) begin
      beats_sum  = beats_sum + (CW+1)'(s_axi.arlen) + (CW+1)'(1);
      bursts_sum = bursts_sum + 10'd1;
    end
    if (r_beat && (beats_sum != '0)) begin
      beats_sum = beats_sum - (CW+1)'(1);
    end
    if (r_last && (bursts_sum != '0)) begin
      bursts_sum = bursts_sum - 10'd1;
    end
    beats_d  = beats_sum[CW-1:0];
    bursts_d = bursts_sum[8:0];
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      arvalid_q <= 1'b0;
      beats_q   <= '0;
      bursts_q  <= '0;
    end else begin
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      arvalid_q <= arvalid_d;
      beats_q   <= beats_d;
      bursts_q  <= bursts_d;
    end
  end

  assign m_axi.arid    = arid_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arlen   = arlen_q;
  assign m_axi.arsize  = arsize_q;
  assign m_axi.arburst = arburst_q;
  assign m_axi.arvalid = arvalid_q;

  assign outstanding_beats  = beats_q;
  assign outstanding_bursts = bursts_q;

endmodule

// File: tb/tb_axi_rd_credit_limit.sv
// Directed bench for axi_rd_credit_limit. Instance A: MAX_BEATS=32,
// MAX_BURSTS=8. Instance B: MAX_BEATS=32, MAX_BURSTS=2.
module tb_axi_rd_credit_limit;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 8;
  localparam int CW = 9;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  axi_rd_credit_limit_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_a ();
  axi_rd_credit_limit_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_a ();
  axi_rd_credit_limit_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_b ();
  axi_rd_credit_limit_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_b ();

  logic [CW-1:0] beats_a, beats_b;
  logic [8:0]    bursts_a, bursts_b;

  axi_rd_credit_limit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
                        .MAX_BEATS(32), .MAX_BURSTS(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .s_axi(s_a), .m_axi(m_a),
    .outstanding_beats(beats_a), .outstanding_bursts(bursts_a)
  );

  axi_rd_credit_limit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
                        .MAX_BEATS(32), .MAX_BURSTS(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .s_axi(s_b), .m_axi(m_b),
    .outstanding_beats(beats_b), .outstanding_bursts(bursts_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ar_a(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
    s_a.arvalid = 1'b1; s_a.arid = id; s_a.araddr = addr; s_a.arlen = len;
    s_a.arsize = 3'd2; s_a.arburst = 2'd1;
  endtask

  task automatic drive_ar_b(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
    s_b.arvalid = 1'b1; s_b.arid = id; s_b.araddr = addr; s_b.arlen = len;
    s_b.arsize = 3'd2; s_b.arburst = 2'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_a.arvalid = 1'b1;
    repeat (3) step();
    checks++; if (m_a.arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %0h expected 0", m_a.arvalid); end
    checks++; if (m_a.araddr !== 32'h0) begin errors++; $display("FAIL reset_araddr: got %0h expected 0", m_a.araddr); end
    checks++; if (m_a.arlen !== 8'h0) begin errors++; $display("FAIL reset_arlen: got %0h expected 0", m_a.arlen); end
    checks++; if (beats_a !== 9'd0) begin errors++; $display("FAIL reset_beats: got %0d expected 0", beats_a); end
    checks++; if (bursts_a !== 9'd0) begin errors++; $display("FAIL reset_bursts: got %0d expected 0", bursts_a); end
    checks++; if (s_a.arready !== 1'b0) begin errors++; $display("FAIL reset_arready: got %0h expected 0", s_a.arready); end
    s_a.arvalid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if (s_a.arready !== 1'b1) begin errors++; $display("FAIL post_reset_arready: got %0h expected 1", s_a.arready); end
    m_a.arready = 1'b1; s_a.rready = 1'b1;
    m_b.arready = 1'b1;
    $display("test_reset done: beats=%0d bursts=%0d", beats_a, bursts_a);
  endtask

  task automatic test_credit_full();
    drive_ar_a(8'd1, 32'h100, 8'd15);
    #1;
    checks++; if (s_a.arready !== 1'b1) begin errors++; $display("FAIL full_acc1_ready: got %0h expected 1", s_a.arready); end
    checks++; if (m_a.arvalid !== 1'b0) begin errors++; $display("FAIL full_latency: got %0h expected 0", m_a.arvalid); end
    step();
    checks++; if (m_a.arvalid !== 1'b1) begin errors++; $display("FAIL full_acc1_mvalid: got %0h expected 1", m_a.arvalid); end
    checks++; if (m_a.araddr !== 32'h100) begin errors++; $display("FAIL full_acc1_addr: got %0h expected 100", m_a.araddr); end
    checks++; if (m_a.arid !== 8'd1) begin errors++; $display("FAIL full_acc1_id: got %0h expected 1", m_a.arid); end
    checks++; if (beats_a !== 9'd16) begin errors++; $display("FAIL full_acc1_beats: got %0d expected 16", beats_a); end
    drive_ar_a(8'd2, 32'h200, 8'd15);
    #1;
    checks++; if (s_a.arready !== 1'b1) begin errors++; $display("FAIL full_acc2_ready: got %0h expected 1", s_a.arready); end
    step();
    checks++; if (m_a.araddr !== 32'h200) begin errors++; $display("FAIL full_acc2_addr: got %0h expected 200", m_a.araddr); end
    checks++; if (beats_a !== 9'd32) begin errors++; $display("FAIL full_acc2_beats: got %0d expected 32", beats_a); end
    checks++; if (bursts_a !== 9'd2) begin errors++; $display("FAIL full_acc2_bursts: got %0d expected 2", bursts_a); end
    drive_ar_a(8'd3, 32'h300, 8'd0);
    #1;
    checks++; if (s_a.arready !== 1'b0) begin errors++; $display("FAIL full_hold_ready: got %0h expected 0", s_a.arready); end
    step();
    checks++; if (m_a.arvalid !== 1'b0) begin errors++; $display("FAIL full_mvalid_clear: got %0h expected 0", m_a.arvalid); end
    checks++; if (beats_a !== 9'd32) begin errors++; $display("FAIL full_hold_beats: got %0d expected 32", beats_a); end
    $display("test_credit_full done: beats=%0d bursts=%0d", beats_a, bursts_a);
  endtask

  task automatic test_release();
    m_a.rvalid = 1'b1; m_a.rlast = 1'b0; m_a.rdata = 32'hDEADBEEF; m_a.rid = 8'd1; m_a.rresp = 2'd2;
    #1;
    checks++; if (s_a.rvalid !== 1'b1) begin errors++; $display("FAIL rel_pass_valid: got %0h expected 1", s_a.rvalid); end
    checks++; if (s_a.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rel_pass_data: got %0h expected deadbeef", s_a.rdata); end
    checks++; if (s_a.rresp !== 2'd2) begin errors++; $display("FAIL rel_pass_resp: got %0h expected 2", s_a.rresp); end
    checks++; if (m_a.rready !== 1'b1) begin errors++; $display("FAIL rel_pass_rready: got %0h expected 1", m_a.rready); end
    checks++; if (s_a.arready !== 1'b0) begin errors++; $display("FAIL rel_conservative: got %0h expected 0", s_a.arready); end
    step();
    m_a.rvalid = 1'b0;
    checks++; if (beats_a !== 9'd31) begin errors++; $display("FAIL rel_beats31: got %0d expected 31", beats_a); end
    #1;
    checks++; if (s_a.arready !== 1'b1) begin errors++; $display("FAIL rel_ready: got %0h expected 1", s_a.arready); end
    step();
    s_a.arvalid = 1'b0;
    checks++; if (beats_a !== 9'd32) begin errors++; $display("FAIL rel_beats32: got %0d expected 32", beats_a); end
    checks++; if (bursts_a !== 9'd3) begin errors++; $display("FAIL rel_bursts3: got %0d expected 3", bursts_a); end
    checks++; if (m_a.araddr !== 32'h300) begin errors++; $display("FAIL rel_addr: got %0h expected 300", m_a.araddr); end
    // Finish burst 1 (15 beats left) and return 7 beats of burst 2
    for (int i = 0; i < 22; i++) begin
      m_a.rvalid = 1'b1; m_a.rlast = (i == 14);
      step();
    end
    m_a.rvalid = 1'b0; m_a.rlast = 1'b0;
    checks++; if (beats_a !== 9'd10) begin errors++; $display("FAIL rel_drain_beats: got %0d expected 10", beats_a); end
    checks++; if (bursts_a !== 9'd2) begin errors++; $display("FAIL rel_drain_bursts: got %0d expected 2", bursts_a); end
    $display("test_release done: beats=%0d bursts=%0d", beats_a, bursts_a);
  endtask

  task automatic test_simultaneous();
    drive_ar_a(8'd4, 32'h400, 8'd3);
    m_a.rvalid = 1'b1; m_a.rlast = 1'b0;
    #1;
    checks++; if (s_a.arready !== 1'b1) begin errors++; $display("FAIL sim_ready: got %0h expected 1", s_a.arready); end
    step();
    s_a.arvalid = 1'b0; m_a.rvalid = 1'b0;
    checks++; if (beats_a !== 9'd13) begin errors++; $display("FAIL sim_beats: got %0d expected 13", beats_a); end
    checks++; if (bursts_a !== 9'd3) begin errors++; $display("FAIL sim_bursts: got %0d expected 3", bursts_a); end
    // Remaining: 8 beats of burst 2, 1 of burst 3, 4 of burst 4
    for (int i = 0; i < 13; i++) begin
      m_a.rvalid = 1'b1; m_a.rlast = (i == 7) || (i == 8) || (i == 12);
      step();
    end
    m_a.rvalid = 1'b0; m_a.rlast = 1'b0;
    checks++; if (beats_a !== 9'd0) begin errors++; $display("FAIL sim_drain_beats: got %0d expected 0", beats_a); end
    checks++; if (bursts_a !== 9'd0) begin errors++; $display("FAIL sim_drain_bursts: got %0d expected 0", bursts_a); end
    $display("test_simultaneous done: beats=%0d bursts=%0d", beats_a, bursts_a);
  endtask

  task automatic test_underflow();
    m_a.rvalid = 1'b1; m_a.rlast = 1'b1;
    step();
    m_a.rvalid = 1'b0; m_a.rlast = 1'b0;
    checks++; if (beats_a !== 9'd0) begin errors++; $display("FAIL uflow_beats: got %0d expected 0", beats_a); end
    checks++; if (bursts_a !== 9'd0) begin errors++; $display("FAIL uflow_bursts: got %0d expected 0", bursts_a); end
    $display("test_underflow done: beats=%0d bursts=%0d", beats_a, bursts_a);
  endtask

  task automatic test_oversize();
    drive_ar_a(8'd6, 32'h1000, 8'd63);
    #1;
    checks++; if (s_a.arready !== 1'b1) begin errors++; $display("FAIL over_ready: got %0h expected 1", s_a.arready); end
    step();
    checks++; if (beats_a !== 9'd64) begin errors++; $display("FAIL over_beats: got %0d expected 64", beats_a); end
    checks++; if (bursts_a !== 9'd1) begin errors++; $display("FAIL over_bursts: got %0d expected 1", bursts_a); end
    drive_ar_a(8'd7, 32'h2000, 8'd31);
    for (int i = 0; i < 64; i++) begin
      m_a.rvalid = 1'b1; m_a.rlast = (i == 63);
      #1;
      checks++; if (s_a.arready !== 1'b0) begin errors++; $display("FAIL over_block_%0d: got %0h expected 0", i, s_a.arready); end
      step();
    end
    m_a.rvalid = 1'b0; m_a.rlast = 1'b0;
    checks++; if (beats_a !== 9'd0) begin errors++; $display("FAIL over_final_beats: got %0d expected 0", beats_a); end
    checks++; if (bursts_a !== 9'd0) begin errors++; $display("FAIL over_final_bursts: got %0d expected 0", bursts_a); end
    #1;
    checks++; if (s_a.arready !== 1'b1) begin errors++; $display("FAIL over_reopen: got %0h expected 1", s_a.arready); end
    step();
    s_a.arvalid = 1'b0;
    checks++; if (beats_a !== 9'd32) begin errors++; $display("FAIL over_next_beats: got %0d expected 32", beats_a); end
    checks++; if (m_a.araddr !== 32'h2000) begin errors++; $display("FAIL over_next_addr: got %0h expected 2000", m_a.araddr); end
    for (int i = 0; i < 32; i++) begin
      m_a.rvalid = 1'b1; m_a.rlast = (i == 31);
      step();
    end
    m_a.rvalid = 1'b0; m_a.rlast = 1'b0;
    checks++; if (beats_a !== 9'd0) begin errors++; $display("FAIL over_drain_beats: got %0d expected 0", beats_a); end
    $display("test_oversize done: beats=%0d bursts=%0d", beats_a, bursts_a);
  endtask

  task automatic test_backpressure_reset();
    m_a.arready = 1'b0;
    drive_ar_a(8'd5, 32'hA0, 8'd3);
    #1;
    checks++; if (s_a.arready !== 1'b1) begin errors++; $display("FAIL bp_first_ready: got %0h expected 1", s_a.arready); end
    step();
    drive_ar_a(8'd6, 32'hB0, 8'd1);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (s_a.arready !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d: got %0h expected 0", i, s_a.arready); end
      checks++; if (m_a.arvalid !== 1'b1) begin errors++; $display("FAIL bp_valid_%0d: got %0h expected 1", i, m_a.arvalid); end
      checks++; if (m_a.araddr !== 32'hA0) begin errors++; $display("FAIL bp_addr_%0d: got %0h expected a0", i, m_a.araddr); end
      checks++; if (m_a.arlen !== 8'd3) begin errors++; $display("FAIL bp_len_%0d: got %0h expected 3", i, m_a.arlen); end
      checks++; if (m_a.arid !== 8'd5) begin errors++; $display("FAIL bp_id_%0d: got %0h expected 5", i, m_a.arid); end
      checks++; if (m_a.arsize !== 3'd2) begin errors++; $display("FAIL bp_size_%0d: got %0h expected 2", i, m_a.arsize); end
      step();
    end
    m_a.arready = 1'b1;
    #1;
    checks++; if (s_a.arready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0h expected 1", s_a.arready); end
    step();
    s_a.arvalid = 1'b0;
    checks++; if (m_a.araddr !== 32'hB0) begin errors++; $display("FAIL bp_next_addr: got %0h expected b0", m_a.araddr); end
    checks++; if (beats_a !== 9'd6) begin errors++; $display("FAIL bp_beats: got %0d expected 6", beats_a); end
    checks++; if (bursts_a !== 9'd2) begin errors++; $display("FAIL bp_bursts: got %0d expected 2", bursts_a); end
    // Reset mid-burst with an R beat in flight and an AR pending downstream
    m_a.arready = 1'b0;
    m_a.rvalid = 1'b1; m_a.rlast = 1'b0;
    rst_n = 1'b0;
    step();
    checks++; if (m_a.arvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %0h expected 0", m_a.arvalid); end
    checks++; if (m_a.araddr !== 32'h0) begin errors++; $display("FAIL rst_mid_addr: got %0h expected 0", m_a.araddr); end
    checks++; if (beats_a !== 9'd0) begin errors++; $display("FAIL rst_mid_beats: got %0d expected 0", beats_a); end
    checks++; if (bursts_a !== 9'd0) begin errors++; $display("FAIL rst_mid_bursts: got %0d expected 0", bursts_a); end
    checks++; if (s_a.arready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %0h expected 0", s_a.arready); end
    m_a.rvalid = 1'b0;
    m_a.arready = 1'b1;
    rst_n = 1'b1;
    step();
    $display("test_backpressure_reset done: beats=%0d bursts=%0d", beats_a, bursts_a);
  endtask

  task automatic test_max_bursts();
    s_b.rready = 1'b0;
    m_b.arready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive_ar_b(8'(k), 32'(16 * (k + 1)), 8'd0);
      #1;
      checks++; if (s_b.arready !== 1'b1) begin errors++; $display("FAIL mb_ready_%0d: got %0h expected 1", k, s_b.arready); end
      step();
      checks++; if (bursts_b !== 9'(k + 1)) begin errors++; $display("FAIL mb_bursts_%0d: got %0d expected %0d", k, bursts_b, k + 1); end
    end
    drive_ar_b(8'd2, 32'h30, 8'd0);
    #1;
    checks++; if (s_b.arready !== 1'b0) begin errors++; $display("FAIL mb_hold_ready: got %0h expected 0", s_b.arready); end
    step();
    checks++; if (bursts_b !== 9'd2) begin errors++; $display("FAIL mb_hold_bursts: got %0d expected 2", bursts_b); end
    checks++; if (m_b.araddr !== 32'h20) begin errors++; $display("FAIL mb_hold_addr: got %0h expected 20", m_b.araddr); end
    m_b.rvalid = 1'b1; m_b.rlast = 1'b1;
    #1;
    checks++; if (m_b.rready !== 1'b0) begin errors++; $display("FAIL mb_stall_rready: got %0h expected 0", m_b.rready); end
    step();
    checks++; if (bursts_b !== 9'd2) begin errors++; $display("FAIL mb_stall_bursts: got %0d expected 2", bursts_b); end
    s_b.rready = 1'b1;
    #1;
    checks++; if (m_b.rready !== 1'b1) begin errors++; $display("FAIL mb_rready: got %0h expected 1", m_b.rready); end
    checks++; if (s_b.arready !== 1'b0) begin errors++; $display("FAIL mb_conservative: got %0h expected 0", s_b.arready); end
    step();
    m_b.rvalid = 1'b0; m_b.rlast = 1'b0;
    checks++; if (bursts_b !== 9'd1) begin errors++; $display("FAIL mb_drop_bursts: got %0d expected 1", bursts_b); end
    checks++; if (beats_b !== 9'd1) begin errors++; $display("FAIL mb_drop_beats: got %0d expected 1", beats_b); end
    #1;
    checks++; if (s_b.arready !== 1'b1) begin errors++; $display("FAIL mb_reopen: got %0h expected 1", s_b.arready); end
    step();
    s_b.arvalid = 1'b0;
    checks++; if (bursts_b !== 9'd2) begin errors++; $display("FAIL mb_third_bursts: got %0d expected 2", bursts_b); end
    checks++; if (beats_b !== 9'd2) begin errors++; $display("FAIL mb_third_beats: got %0d expected 2", beats_b); end
    checks++; if (m_b.araddr !== 32'h30) begin errors++; $display("FAIL mb_third_addr: got %0h expected 30", m_b.araddr); end
    $display("test_max_bursts done: beats=%0d bursts=%0d", beats_b, bursts_b);
  endtask

  initial begin
    rst_n = 1'b0;
    s_a.arid = '0; s_a.araddr = '0; s_a.arlen = '0; s_a.arsize = '0; s_a.arburst = '0;
    s_a.arvalid = 1'b0; s_a.rready = 1'b0;
    m_a.arready = 1'b0; m_a.rid = '0; m_a.rdata = '0; m_a.rresp = '0; m_a.rlast = 1'b0; m_a.rvalid = 1'b0;
    s_b.arid = '0; s_b.araddr = '0; s_b.arlen = '0; s_b.arsize = '0; s_b.arburst = '0;
    s_b.arvalid = 1'b0; s_b.rready = 1'b0;
    m_b.arready = 1'b0; m_b.rid = '0; m_b.rdata = '0; m_b.rresp = '0; m_b.rlast = 1'b0; m_b.rvalid = 1'b0;

    test_reset();
    test_credit_full();
    test_release();
    test_simultaneous();
    test_underflow();
    test_oversize();
    test_backpressure_reset();
    test_max_bursts();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
